// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
// Shared types and helpers for the dual-port front-end of the single-port
// memory block.
//   port_id_e   : identifies requester A or B (also the rr pointer encoding)
//   arb_state_e : top-level FSM states (INIT walks the array, RUN serves ports)
//   rsp_tag_t   : {valid, port} tag carried alongside an outstanding read
//   depth()     : number of words for a given address width
// -----------------------------------------------------------------------------
package dpram_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
    } rsp_tag_t;

    function automatic int depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter. Bit 0 is port A, bit 1 is port B.
// A lone requester is granted at once; on contention the port named by the
// pointer wins. After any grant the pointer moves to the port not granted, and
// it holds through idle cycles.
//   clk, rst   : clock, asynchronous active-high reset (pointer -> PORT_A)
//   req_i[1:0] : request vector (already masked by the caller when not serving)
//   grant_o    : one-hot-or-zero grant vector, combinational from req_i
// -----------------------------------------------------------------------------
module rr_arbiter2
    import dpram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    port_id_e rr_ptr_q;
    port_id_e rr_ptr_d;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        grant_o  = req_i;
        rr_ptr_d = rr_ptr_q;

        if (req_i[0] && req_i[1]) begin
            grant_o = (rr_ptr_q == PORT_A) ? 2'b01 : 2'b10;
        end

        if (grant_o[0]) begin
            rr_ptr_d = PORT_B;
        end else if (grant_o[1]) begin
            rr_ptr_d = PORT_A;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= PORT_A;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_port_arbiter
// Front-end for the single-port memory block (1-cycle registered read, write
// on the rising edge when enabled). After reset it writes INIT_VALUE to every
// address, then serves two valid/ready request ports with round-robin
// arbitration and returns read data to the port that issued the read.
//   clk, rst             : clock, asynchronous active-high reset
//   a_req_* / b_req_*    : request ports (valid/ready, we, addr, wdata)
//   a_rsp_* / b_rsp_*    : single-cycle read responses, no backpressure
//   mem_*                : registered command to the memory, mem_r_data back
//   init_done            : high once the whole array has been initialised
// -----------------------------------------------------------------------------
module dpram_port_arbiter
    import dpram_pkg::*;
#(
    parameter int                         DATA_WIDTH = 64,
    parameter int                         ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0]      INIT_VALUE = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,

    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data,

    output logic                  init_done
);

    localparam int                  DEPTH    = depth(ADDR_WIDTH);
    // Counter is one bit wider than the address so reaching DEPTH is the
    // "all words written" condition rather than a wrap back to zero.
    localparam logic [ADDR_WIDTH:0] INIT_END = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    arb_state_e              state_q,      state_d;
    logic [ADDR_WIDTH:0]     init_cnt_q,   init_cnt_d;
    logic                    init_done_q,  init_done_d;
    logic                    mem_we_q,     mem_we_d;
    logic                    mem_re_q,     mem_re_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q,  mem_wdata_d;
    // Stage 0 is aligned with the registered command, stage 1 with the cycle
    // in which the memory presents the read data.
    rsp_tag_t                tag0_q,       tag0_d;
    rsp_tag_t                tag1_q;

    logic [1:0]              req;
    logic [1:0]              grant;
    logic                    handshake;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // Requests are masked outside RUN, so readies (= grants) stay low in INIT.
    assign req = {b_req_valid, a_req_valid} & {2{state_q == RUN}};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .grant_o (grant)
    );

    assign a_req_ready = grant[0];
    assign b_req_ready = grant[1];
    assign handshake   = |grant;

    // Only the granted port's fields are used, so a port's addr/wdata never
    // reach state while its valid is low.
    assign sel_we    = grant[1] ? b_req_we    : a_req_we;
    assign sel_addr  = grant[1] ? b_req_addr  : a_req_addr;
    assign sel_wdata = grant[1] ? b_req_wdata : a_req_wdata;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag0_d      = '0;

        case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_END) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = init_cnt_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = INIT_VALUE;
                    init_cnt_d  = init_cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (handshake) begin
                    mem_we_d     = sel_we;
                    mem_re_d     = !sel_we;
                    mem_addr_d   = sel_addr;
                    mem_wdata_d  = sel_wdata;
                    tag0_d.valid = !sel_we;
                    tag0_d.port  = grant[1] ? PORT_B : PORT_A;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // NOTE: the response tags are reset along with the FSM so any read in
    // flight when reset hits is dropped instead of producing a stray pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag0_q      <= '0;
            tag1_q      <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag0_q;
        end
    end

    assign mem_write_en = mem_we_q;
    assign mem_read_en  = mem_re_q;
    assign mem_addr     = mem_addr_q;
    assign mem_w_data   = mem_wdata_q;
    assign init_done    = init_done_q;

    assign a_rsp_valid = tag1_q.valid && (tag1_q.port == PORT_A);
    assign b_rsp_valid = tag1_q.valid && (tag1_q.port == PORT_B);
    assign a_rsp_rdata = a_rsp_valid ? mem_r_data : '0;
    assign b_rsp_rdata = b_rsp_valid ? mem_r_data : '0;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_port_arbiter
// Directed bench for dpram_port_arbiter with a behavioural single-port memory
// (1-cycle registered read, write on the rising edge). A table of per-cycle
// vectors covers arbitration and responses; hand-written sequences cover init,
// command registering, hold on idle, and reset in the middle of a read.
// -----------------------------------------------------------------------------
module tb_dpram_port_arbiter;

    localparam int          DW   = 64;
    localparam int          AW   = 6;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] DB   = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] W9   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] JNK  = 64'h5A5A_1234_C3C3_9876;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req_valid, a_req_ready, a_req_we;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata;
    logic          a_rsp_valid;
    logic [DW-1:0] a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_we;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata;
    logic          b_rsp_valid;
    logic [DW-1:0] b_rsp_rdata;
    logic          mem_write_en, mem_read_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_w_data;
    logic [DW-1:0] mem_r_data;
    logic          init_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .INIT_VALUE (ONES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_req_valid  (a_req_valid),
        .a_req_ready  (a_req_ready),
        .a_req_we     (a_req_we),
        .a_req_addr   (a_req_addr),
        .a_req_wdata  (a_req_wdata),
        .a_rsp_valid  (a_rsp_valid),
        .a_rsp_rdata  (a_rsp_rdata),
        .b_req_valid  (b_req_valid),
        .b_req_ready  (b_req_ready),
        .b_req_we     (b_req_we),
        .b_req_addr   (b_req_addr),
        .b_req_wdata  (b_req_wdata),
        .b_rsp_valid  (b_rsp_valid),
        .b_rsp_rdata  (b_rsp_rdata),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_addr     (mem_addr),
        .mem_w_data   (mem_w_data),
        .mem_r_data   (mem_r_data),
        .init_done    (init_done)
    );

    // Behavioural model of the team's single-port memory.
    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_w_data;
        if (mem_read_en)  mem_r_data    <= mem[mem_addr];
    end

    typedef struct {
        logic          av;
        logic          awe;
        logic [AW-1:0] aaddr;
        logic [DW-1:0] awd;
        logic          bv;
        logic          bwe;
        logic [AW-1:0] baddr;
        logic [DW-1:0] bwd;
        logic          ar;
        logic          br;
        logic          arv;
        logic          brv;
        logic [DW-1:0] ard;
        logic [DW-1:0] brd;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        a_req_valid = v.av;  a_req_we = v.awe; a_req_addr = v.aaddr; a_req_wdata = v.awd;
        b_req_valid = v.bv;  b_req_we = v.bwe; b_req_addr = v.baddr; b_req_wdata = v.bwd;
    endtask

    task automatic idle_ports();
        a_req_valid = 1'b0; a_req_we = 1'b1; a_req_addr = 6'h2a; a_req_wdata = JNK;
        b_req_valid = 1'b0; b_req_we = 1'b1; b_req_addr = 6'h15; b_req_wdata = ~JNK;
    endtask

    // Walks the init sequence starting right after the first edge with rst low.
    task automatic check_init(input string tag);
        for (int i = 0; i < 64; i++) begin
            check({tag, " init we"},   64'(mem_write_en), 64'd1);
            check({tag, " init addr"}, 64'(mem_addr),     64'(i));
            check({tag, " init data"}, mem_w_data,        ONES);
            check({tag, " init rdy"},  64'({a_req_ready, b_req_ready}), 64'd0);
            check({tag, " init done"}, 64'(init_done),    64'd0);
            tick();
        end
        check({tag, " init end we"}, 64'(mem_write_en), 64'd0);
        check({tag, " init_done"},   64'(init_done),    64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Vector table: one entry per RUN cycle, rr pointer starts at A.
        //           av awe aaddr  awd   bv bwe baddr  bwd   ar br arv brv ard   brd
        vecs[0]  = '{1, 1, 6'd5,  DB,   0, 1, 6'd33, JNK,  1, 0, 0,  0,  0,    0};
        vecs[1]  = '{1, 0, 6'd5,  JNK,  0, 1, 6'd44, JNK,  1, 0, 0,  0,  0,    0};
        vecs[2]  = '{0, 1, 6'd9,  JNK,  1, 0, 6'd7,  JNK,  0, 1, 0,  0,  0,    0};
        vecs[3]  = '{0, 1, 6'd5,  JNK,  0, 1, 6'd5,  JNK,  0, 0, 1,  0,  DB,   0};
        vecs[4]  = '{0, 0, 6'd8,  JNK,  0, 0, 6'd8,  JNK,  0, 0, 0,  1,  0,    ONES};
        vecs[5]  = '{0, 1, 6'd0,  JNK,  1, 0, 6'd3,  JNK,  0, 1, 0,  0,  0,    0};
        vecs[6]  = '{1, 0, 6'd1,  JNK,  1, 0, 6'd2,  JNK,  1, 0, 0,  0,  0,    0};
        vecs[7]  = '{1, 0, 6'd1,  JNK,  1, 0, 6'd2,  JNK,  0, 1, 0,  1,  0,    ONES};
        vecs[8]  = '{1, 0, 6'd1,  JNK,  1, 0, 6'd2,  JNK,  1, 0, 1,  0,  ONES, 0};
        vecs[9]  = '{1, 0, 6'd1,  JNK,  1, 0, 6'd2,  JNK,  0, 1, 0,  1,  0,    ONES};
        vecs[10] = '{0, 1, 6'd11, JNK,  0, 1, 6'd12, JNK,  0, 0, 1,  0,  ONES, 0};
        vecs[11] = '{0, 1, 6'd13, JNK,  0, 1, 6'd14, JNK,  0, 0, 0,  1,  0,    ONES};
        vecs[12] = '{0, 0, 6'd63, JNK,  0, 0, 6'd62, JNK,  0, 0, 0,  0,  0,    0};

        // Reset with both valids high: readies must still decode to 0.
        rst = 1'b1;
        idle_ports();
        a_req_valid = 1'b1;
        b_req_valid = 1'b1;
        a_req_we    = 1'b0;
        b_req_we    = 1'b0;
        #12;
        check("rst mem_we",    64'(mem_write_en), 64'd0);
        check("rst mem_re",    64'(mem_read_en),  64'd0);
        check("rst mem_addr",  64'(mem_addr),     64'd0);
        check("rst mem_wdata", mem_w_data,        64'd0);
        check("rst rdy",       64'({a_req_ready, b_req_ready}), 64'd0);
        check("rst rsp",       64'({a_rsp_valid, b_rsp_valid}), 64'd0);
        check("rst init_done", 64'(init_done),    64'd0);
        #4;
        rst = 1'b0;
        tick();
        check_init("first");

        // Table-driven RUN cycles.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d a_ready", i),     64'(a_req_ready), 64'(vecs[i].ar));
            check($sformatf("v%0d b_ready", i),     64'(b_req_ready), 64'(vecs[i].br));
            check($sformatf("v%0d a_rsp_valid", i), 64'(a_rsp_valid), 64'(vecs[i].arv));
            check($sformatf("v%0d b_rsp_valid", i), 64'(b_rsp_valid), 64'(vecs[i].brv));
            check($sformatf("v%0d a_rsp_rdata", i), a_rsp_rdata,      vecs[i].ard);
            check($sformatf("v%0d b_rsp_rdata", i), b_rsp_rdata,      vecs[i].brd);
            tick();
        end

        // Command registering, then hold of addr/data while idle with junk inputs.
        idle_ports();
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 6'd9; a_req_wdata = W9;
        #1;
        check("cmd a_ready", 64'(a_req_ready), 64'd1);
        tick();
        idle_ports();
        #1;
        check("cmd we",    64'(mem_write_en), 64'd1);
        check("cmd re",    64'(mem_read_en),  64'd0);
        check("cmd addr",  64'(mem_addr),     64'd9);
        check("cmd wdata", mem_w_data,        W9);
        tick();
        check("hold we",    64'(mem_write_en), 64'd0);
        check("hold re",    64'(mem_read_en),  64'd0);
        check("hold addr",  64'(mem_addr),     64'd9);
        check("hold wdata", mem_w_data,        W9);

        // Reset one cycle after an A read handshake: the read must vanish.
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'd5;
        #1;
        check("pre-rst a_ready", 64'(a_req_ready), 64'd1);
        tick();
        idle_ports();
        check("pre-rst mem_re", 64'(mem_read_en), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid-rst mem_re",    64'(mem_read_en), 64'd0);
        check("mid-rst init_done", 64'(init_done),   64'd0);
        tick();
        check("mid-rst a_rsp", 64'(a_rsp_valid), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        check("post-rst a_rsp", 64'(a_rsp_valid), 64'd0);
        check("post-rst b_rsp", 64'(b_rsp_valid), 64'd0);
        check_init("second");

        // Address 5 held DB before the reset; re-init must have restored ONES.
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'd5;
        #1;
        check("reinit a_ready", 64'(a_req_ready), 64'd1);
        tick();
        idle_ports();
        #1;
        check("reinit early rsp", 64'(a_rsp_valid), 64'd0);
        tick();
        check("reinit a_rsp_valid", 64'(a_rsp_valid), 64'd1);
        check("reinit a_rsp_rdata", a_rsp_rdata,      ONES);
        check("reinit b_rsp_valid", 64'(b_rsp_valid), 64'd0);
        tick();
        check("reinit rsp pulse", 64'(a_rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Upstream front-end for the team's single-port `memory` block (1-cycle registered read, write on posedge when enabled).
- Presents two independent request ports, A and B, with valid/ready handshakes and serialises them onto the one memory command interface using round-robin arbitration.
- Routes read data back to the requesting port.
- Owns memory initialisation: after reset it walks every address, writing INIT_VALUE, before accepting traffic.

Parameters:
- DATA_WIDTH, 64, word width of requests, memory data and responses.
- ADDR_WIDTH, 6, address width; memory depth DEPTH = 2**ADDR_WIDTH.
- INIT_VALUE, {DATA_WIDTH{1'b1}}, word written to every location during init.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- a_req_valid  in  1  port A request present.
- a_req_ready  out  1  port A request accepted this cycle.
- a_req_we  in  1  port A: 1 = write, 0 = read.
- a_req_addr  in  ADDR_WIDTH  port A address.
- a_req_wdata  in  DATA_WIDTH  port A write data.
- a_rsp_valid  out  1  port A read data valid (single-cycle pulse, no backpressure).
- a_rsp_rdata  out  DATA_WIDTH  port A read data.
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: same as port A, for port B.
- mem_write_en  out  1  registered memory write enable.
- mem_read_en  out  1  registered memory read enable.
- mem_addr  out  ADDR_WIDTH  registered memory address.
- mem_w_data  out  DATA_WIDTH  registered memory write data.
- mem_r_data  in  DATA_WIDTH  memory read data, valid one cycle after mem_read_en is sampled.
- init_done  out  1  high once initialisation has completed.

Behaviour:
Reset values (asynchronous):
- state = INIT, init_cnt = 0, rr_ptr = A.
- All mem_* outputs = 0; both *_rsp_valid = 0; response pipeline cleared; init_done = 0.
- *_req_ready = 0, because readies decode from state.

FSM states: INIT and RUN.

INIT:
- Each cycle, register mem_write_en = 1, mem_addr = init_cnt[ADDR_WIDTH-1:0], mem_w_data = INIT_VALUE, then increment init_cnt.
- init_cnt is ADDR_WIDTH+1 bits wide.
- After the write of address DEPTH-1 has been registered, go to RUN and set init_done = 1. Exactly DEPTH init writes are issued.
- Both readies stay 0 throughout INIT.

RUN, arbitration (combinational):
- Only A valid: grant A. Only B valid: grant B.
- Both valid: grant the port named by rr_ptr.
- After any grant, rr_ptr = the port not granted.
- rr_ptr is unchanged in idle cycles.
- x_req_ready = grant_x. At most one ready is high per cycle.

RUN, command:
- On a handshake (valid && ready at an edge), register mem_write_en = we, mem_read_en = !we, and mem_addr / mem_w_data from the granted port.
- With no handshake, both enables are registered to 0; addr and data hold.

Read latency:
- Handshake at edge E0; the memory samples the command at E1; mem_r_data is valid after E1.
- The rsp_valid of the originating port is high for exactly the cycle between E1 and E2.
- Response routing uses a 2-stage pipeline of {valid, port_id}.
- x_rsp_rdata = mem_r_data while x_rsp_valid = 1, else 0.

Throughput and ordering:
- Back-to-back grants are allowed every cycle, so responses may occur every cycle.
- Responses come back in grant order.

Hazards:
- Accesses are serialised, so no same-cycle read/write collision exists at the memory.
- A read granted the cycle after a write to the same address returns the new data.

Writes produce no response.

Reset mid-operation:
- In-flight reads are discarded (no rsp_valid is issued for them).
- Return to INIT and re-initialise the whole array.

X-safety: address and write data are don't-care when valid = 0 and must not affect state.

Decomposition:
- Package dpram_pkg: typedef port_id_e {PORT_A, PORT_B}, typedef arb_state_e {INIT, RUN}, a localparam function depth(ADDR_WIDTH).
- One sub-module, rr_arbiter2: 2-requester round-robin arbiter (req[1:0], grant[1:0], rr_ptr register). Everything else stays in the top.

Test Plan:
- Reset, then idle: exactly 64 mem writes at addr 0..63 with data 64'hFFFF_FFFF_FFFF_FFFF; init_done rises the cycle after the last write; no ready is high before that.
- After init, A writes addr 5 = 64'hDEAD_BEEF_0000_0001, then the next cycle A reads addr 5: a_rsp_valid pulses 2 cycles after the read handshake with that data; b_rsp_valid stays 0.
- A and B both hold valid reads (A addr 1, B addr 2) for 4 cycles: grants go A, B, A, B; responses alternate a/b with init data 64'hFF..FF in the same order.
- B reads addr 7 (never written) after init: b_rsp_rdata = INIT_VALUE.
- Both ports idle, then a single B request while rr_ptr = A: B is granted immediately; the next contended cycle grants A.
- Assert rst one cycle after an A read handshake: no a_rsp_valid appears; init restarts at addr 0; an earlier write to addr 5 reads back as 64'hFF..FF after re-init.
